// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: port A (no backpressure) wins each edge; port B results
// pass through a FIFO whose entries are squashed by younger A writes to the same register.
module wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    A_VALID,
  input  logic [4:0]              A_ADR,
  input  logic [31:0]             A_DATA,
  output logic                    A_HOLD,
  input  logic                    B_VALID,
  output logic                    B_READY,
  input  logic [4:0]              B_ADR,
  input  logic [31:0]             B_DATA,
  output logic                    WB_EN,
  output logic [4:0]              WB_ADR,
  output logic [31:0]             WB_DATA,
  output logic [$clog2(DEPTH):0]  B_COUNT,
  output logic                    ERR
);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [PW:0]   FULL = (PW + 1)'(DEPTH);
  localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);

  logic [4:0]       adr_q [DEPTH];
  logic [31:0]      dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_q, wr_q;
  logic [PW:0]      cnt_q, cnt_d;
  logic [AW-1:0]    age_q, age_d;
  logic             hold_q, err_q;
  logic             wb_en_q;
  logic [4:0]       wb_adr_q;
  logic [31:0]      wb_dat_q;

  logic a_wr, empty, head_vld, push, pop;

  assign a_wr     = A_VALID && (A_ADR != 5'd0);
  assign empty    = (cnt_q == '0);
  assign head_vld = !empty && vld_q[rd_q];
  assign B_READY  = (cnt_q < FULL);
  assign push     = B_VALID && B_READY && (B_ADR != 5'd0);
  // A squashed head leaves even while A owns the write port.
  assign pop      = !empty && (!vld_q[rd_q] || !a_wr);

  always_comb begin
    vld_d = vld_q;
    if (pop)
      vld_d[rd_q] = 1'b0;
    if (push)
      vld_d[wr_q] = 1'b1;
    // A is always younger than anything in the FIFO, including an entry pushed this edge.
    if (a_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (((push && (wr_q == PW'(i))) ? B_ADR : adr_q[i]) == A_ADR)
          vld_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
    age_d = age_q;
    if (pop || empty)
      age_d = '0;
    else if (head_vld && (age_q < AGE_MAX))
      age_d = age_q + AW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      age_q    <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
      wb_en_q  <= 1'b0;
      wb_adr_q <= 5'd0;
      wb_dat_q <= 32'd0;
    end else begin
      vld_q  <= vld_d;
      rd_q   <= rd_q + PW'(pop);
      wr_q   <= wr_q + PW'(push);
      cnt_q  <= cnt_d;
      age_q  <= age_d;
      hold_q <= (age_d >= AGE_MAX);
      err_q  <= err_q || (a_wr && hold_q);
      if (a_wr) begin
        wb_en_q  <= 1'b1;
        wb_adr_q <= A_ADR;
        wb_dat_q <= A_DATA;
      end else if (head_vld) begin
        wb_en_q  <= 1'b1;
        wb_adr_q <= adr_q[rd_q];
        wb_dat_q <= dat_q[rd_q];
      end else begin
        wb_en_q  <= 1'b0;
      end
    end
  end

  // Payload storage carries no reset; validity lives in vld_q.
  always_ff @(posedge CLK) begin
    if (push) begin
      adr_q[wr_q] <= B_ADR;
      dat_q[wr_q] <= B_DATA;
    end
  end

  assign A_HOLD  = hold_q;
  assign ERR     = err_q;
  assign WB_EN   = wb_en_q;
  assign WB_ADR  = wb_adr_q;
  assign WB_DATA = wb_dat_q;
  assign B_COUNT = cnt_q;

endmodule
